cnt_down_m60: RTL

- Countdown timer for the digital clock: MM:SS down-counter in BCD.
- Shares the prescale-then-count structure of the up-counting time chain, but counts the other direction: it loads a preset, decrements once per prescaled tick, and flags expiry at 00:00.
- Feeds the display mux and the alarm/buzzer logic.

---
 rtl/cnt_down_m60.sv | 138 +++++++++++++
 1 files changed

// File: rtl/cnt_down_m60.sv
// MM:SS BCD countdown timer: load a preset, decrement once per prescaled tick,
// flag expiry at 00:00 with a one-cycle done pulse and a sticky alarm level.
module cnt_down_m60 #(
   parameter int PRESCALE = 600
) (
   input  logic       in_clk,
   input  logic       rst,
   input  logic       load,
   input  logic       start,
   input  logic       stop,
   input  logic       clr_alarm,
   input  logic [3:0] pre_mt,
   input  logic [3:0] pre_mo,
   input  logic [3:0] pre_st,
   input  logic [3:0] pre_so,
   output logic [3:0] mt,
   output logic [3:0] mo,
   output logic [3:0] st,
   output logic [3:0] so,
   output logic       running,
   output logic       done,
   output logic       alarm
);

   localparam logic [9:0] PRE_LAST = 10'(PRESCALE - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUN     = 2'd1,
      S_PAUSE   = 2'd2,
      S_EXPIRED = 2'd3
   } state_t;

   state_t     r_state, w_state;
   logic [9:0] r_pre, w_pre;
   logic [3:0] r_mt, r_mo, r_st, r_so;
   logic [3:0] w_mt, w_mo, w_st, w_so;
   logic       r_done, w_done;
   logic       r_alarm, w_alarm;

   logic [3:0] w_dec_mt, w_dec_mo, w_dec_st, w_dec_so;
   logic       w_b_so, w_b_st, w_b_mo;
   logic       w_zero, w_dec_zero;

   function automatic logic [3:0] clamp9(input logic [3:0] d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

   function automatic logic [3:0] clamp5(input logic [3:0] d);
      return (d > 4'd5) ? 4'd5 : d;
   endfunction

   // BCD borrow chain; mt floors at 0 so digits stay in range even if misused
   assign w_b_so     = (r_so == 4'd0);
   assign w_dec_so   = w_b_so ? 4'd9 : (r_so - 4'd1);
   assign w_b_st     = w_b_so && (r_st == 4'd0);
   assign w_dec_st   = w_b_so ? ((r_st == 4'd0) ? 4'd5 : (r_st - 4'd1)) : r_st;
   assign w_b_mo     = w_b_st && (r_mo == 4'd0);
   assign w_dec_mo   = w_b_st ? ((r_mo == 4'd0) ? 4'd9 : (r_mo - 4'd1)) : r_mo;
   assign w_dec_mt   = w_b_mo ? ((r_mt == 4'd0) ? 4'd0 : (r_mt - 4'd1)) : r_mt;
   assign w_zero     = ({r_mt, r_mo, r_st, r_so} == 16'd0);
   assign w_dec_zero = ({w_dec_mt, w_dec_mo, w_dec_st, w_dec_so} == 16'd0);

   always_comb begin
      w_state = r_state;
      w_pre   = r_pre;
      w_mt    = r_mt;
      w_mo    = r_mo;
      w_st    = r_st;
      w_so    = r_so;
      w_done  = 1'b0;
      w_alarm = r_alarm & ~clr_alarm;
      if (load) begin
         w_mt    = clamp9(pre_mt);
         w_mo    = clamp9(pre_mo);
         w_st    = clamp5(pre_st);
         w_so    = clamp9(pre_so);
         w_pre   = 10'd0;
         w_state = S_IDLE;
         w_alarm = 1'b0;
      end else if (stop && (r_state == S_RUN)) begin
         // prescaler kept so a resume finishes the partial second
         w_state = S_PAUSE;
      end else if (start && ((r_state == S_IDLE) || (r_state == S_PAUSE)) && !w_zero) begin
         w_state = S_RUN;
      end else if (r_state == S_RUN) begin
         if (r_pre == PRE_LAST) begin
            w_pre = 10'd0;
            w_mt  = w_dec_mt;
            w_mo  = w_dec_mo;
            w_st  = w_dec_st;
            w_so  = w_dec_so;
            if (w_dec_zero) begin
               w_state = S_EXPIRED;
               w_done  = 1'b1;
               w_alarm = 1'b1;
            end else begin
               w_state = S_RUN;
            end
         end else begin
            w_pre = r_pre + 10'd1;
         end
      end else begin
         w_state = r_state;
      end
   end

   always_ff @(posedge in_clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_pre   <= 10'd0;
         r_mt    <= 4'd0;
         r_mo    <= 4'd0;
         r_st    <= 4'd0;
         r_so    <= 4'd0;
         r_done  <= 1'b0;
         r_alarm <= 1'b0;
      end else begin
         r_state <= w_state;
         r_pre   <= w_pre;
         r_mt    <= w_mt;
         r_mo    <= w_mo;
         r_st    <= w_st;
         r_so    <= w_so;
         r_done  <= w_done;
         r_alarm <= w_alarm;
      end
   end

   assign mt      = r_mt;
   assign mo      = r_mo;
   assign st      = r_st;
   assign so      = r_so;
   assign running = (r_state == S_RUN);
   assign done    = r_done;
   assign alarm   = r_alarm;

endmodule
